// File: rtl/serial_add_sub.sv
// serial_add_sub
//   Bit-serial adder/subtractor. One result bit is produced per clock, LSB
//   first. Subtraction is done as A + ~B + 1: B is inverted at acceptance
//   and the initial carry is set to 1.
//
// Ports
//   clk    in   sole clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request a new operation (accepted in IDLE or DONE)
//   m      in   mode: 0 = A+B, 1 = A-B (sampled with start)
//   A, B   in   WIDTH-bit operands (sampled with start)
//   busy   out  high while the serial operation runs
//   done   out  one-cycle pulse when S/c/v have just been updated
//   S      out  WIDTH-bit result, modulo 2^WIDTH
//   c      out  carry out of MSB (subtract: 1 = no borrow)
//   v      out  signed overflow
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; outputs hold last result
// RUN   | one bit per cycle, WIDTH cycles, busy=1
// DONE  | S/c/v freshly loaded, done=1; start here begins the next op

module serial_add_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             m,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             c,
  output logic             v
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sum_bit;
  logic             carry_out;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    s_d       = s_q;
    c_d       = c_q;
    v_d       = v_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    carry_out = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = A;
          b_d     = B ^ {WIDTH{m}};
          carry_d = m;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {sum_bit, sum_q[WIDTH-1:1]};
        carry_d = carry_out;
        idx_d   = idx_q + IDX_W'(1);
        busy_d  = 1'b1;
        if (idx_q == LAST_IDX) begin
          // On the MSB cycle carry_q is the carry into the MSB, so the
          // overflow flag can be formed here without a separate register.
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          idx_d   = '0;
          s_d     = {sum_bit, sum_q[WIDTH-1:1]};
          c_d     = carry_out;
          v_d     = carry_q ^ carry_out;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      c_q     <= c_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign c    = c_q;
  assign v    = v_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: a WIDTH=4 and a WIDTH=8 instance share
// the clock and reset. Table vectors are followed by hand-written sequences
// for back-to-back operation, start during RUN, and reset during RUN.

module tb_serial_add_sub;

  typedef struct {
    bit         w8;
    bit         m;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    bit         c;
    bit         v;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, m4, busy4, done4, c4, v4;
  logic [3:0] a4, b4, s4;
  logic       start8, m8, busy8, done8, c8, v8;
  logic [7:0] a8, b8, s8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .m(m4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .S(s4), .c(c4), .v(v4)
  );

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .m(m8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .S(s8), .c(c8), .v(v8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] get_s(input bit w8);
    return w8 ? s8 : {4'b0, s4};
  endfunction
  function automatic logic get_busy(input bit w8);
    return w8 ? busy8 : busy4;
  endfunction
  function automatic logic get_done(input bit w8);
    return w8 ? done8 : done4;
  endfunction
  function automatic logic get_c(input bit w8);
    return w8 ? c8 : c4;
  endfunction
  function automatic logic get_v(input bit w8);
    return w8 ? v8 : v4;
  endfunction

  task automatic drive(input vec_t t);
    if (t.w8) begin
      a8 = t.a; b8 = t.b; m8 = t.m; start8 = 1'b1;
    end else begin
      a4 = t.a[3:0]; b4 = t.b[3:0]; m4 = t.m; start4 = 1'b1;
    end
  endtask

  // Single operation from IDLE: checks busy window, output hold during RUN,
  // done timing and results.
  task automatic do_op(input vec_t t, input string nm);
    int         w;
    int         busy_bad;
    int         hold_bad;
    logic [7:0] pre_s;
    w        = t.w8 ? 8 : 4;
    busy_bad = 0;
    hold_bad = 0;
    @(negedge clk);
    pre_s = get_s(t.w8);
    drive(t);
    for (int k = 1; k <= w; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start4 = 1'b0;
        start8 = 1'b0;
      end
      if (get_busy(t.w8) !== 1'b1 || get_done(t.w8) !== 1'b0) busy_bad++;
      if (get_s(t.w8) !== pre_s) hold_bad++;
    end
    @(negedge clk);
    chk({nm, " busy_window"}, 32'(busy_bad), 32'd0);
    chk({nm, " hold_in_run"}, 32'(hold_bad), 32'd0);
    chk({nm, " done"}, {30'd0, get_busy(t.w8), get_done(t.w8)}, 32'b01);
    chk({nm, " S"}, {24'd0, get_s(t.w8)}, {24'd0, t.s});
    chk({nm, " c"}, {31'd0, get_c(t.w8)}, {31'd0, t.c});
    chk({nm, " v"}, {31'd0, get_v(t.w8)}, {31'd0, t.v});
  endtask

  vec_t vecs[12];
  vec_t b2b[3];

  initial begin
    //         w8  m   A      B      S      c  v
    vecs[0]  = '{0, 1, 8'h07, 8'h02, 8'h05, 1, 0};
    vecs[1]  = '{0, 0, 8'h07, 8'h01, 8'h08, 0, 1};
    vecs[2]  = '{0, 0, 8'h08, 8'h08, 8'h00, 1, 1};
    vecs[3]  = '{1, 1, 8'h80, 8'h01, 8'h7F, 1, 1};
    vecs[4]  = '{1, 0, 8'hFF, 8'h01, 8'h00, 1, 0};
    vecs[5]  = '{0, 1, 8'h00, 8'h00, 8'h00, 1, 0};
    vecs[6]  = '{0, 0, 8'h05, 8'h06, 8'h0B, 0, 1};
    vecs[7]  = '{1, 0, 8'h3C, 8'h41, 8'h7D, 0, 0};
    vecs[8]  = '{1, 1, 8'h10, 8'h20, 8'hF0, 0, 0};
    vecs[9]  = '{0, 1, 8'h08, 8'h01, 8'h07, 1, 1};
    vecs[10] = '{0, 0, 8'h03, 8'h04, 8'h07, 0, 0};
    vecs[11] = '{1, 0, 8'h7F, 8'h01, 8'h80, 0, 1};

    b2b[0] = '{0, 1, 8'h0A, 8'h01, 8'h09, 1, 0};
    b2b[1] = '{0, 1, 8'h0F, 8'h0D, 8'h02, 1, 0};
    b2b[2] = '{0, 1, 8'h03, 8'h0E, 8'h05, 0, 0};

    rst = 1'b1;
    start4 = 1'b0; m4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; m8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("reset4", {25'd0, busy4, done4, s4, c4, v4}, 32'd0);
    chk("reset8", {21'd0, busy8, done8, s8, c8, v8}, 32'd0);

    for (int i = 0; i < 12; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: start held high, next operands presented in DONE.
    begin
      int bad_busy;
      bad_busy = 0;
      @(negedge clk);
      drive(b2b[0]);
      for (int i = 0; i < 3; i++) begin
        for (int k = 1; k <= 4; k++) begin
          @(negedge clk);
          if (busy4 !== 1'b1 || done4 !== 1'b0) bad_busy++;
        end
        @(negedge clk);
        chk($sformatf("b2b%0d done", i), {30'd0, busy4, done4}, 32'b01);
        chk($sformatf("b2b%0d result", i), {26'd0, s4, c4, v4},
            {26'd0, b2b[i].s[3:0], b2b[i].c, b2b[i].v});
        if (i < 2) drive(b2b[i+1]);
        else start4 = 1'b0;
      end
      chk("b2b busy_no_gap", 32'(bad_busy), 32'd0);
      @(negedge clk);
      chk("b2b idle_after", {30'd0, busy4, done4}, 32'b00);
    end

    // start with new operands during RUN must be ignored.
    begin
      int n_done;
      int done_at;
      n_done  = 0;
      done_at = -1;
      @(negedge clk);
      drive(vecs[0]);
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (k == 1) start4 = 1'b0;
        if (k == 2) begin
          start4 = 1'b1; a4 = 4'hF; b4 = 4'h1; m4 = 1'b0;
        end
        if (k == 3) start4 = 1'b0;
        if (done4 === 1'b1) begin
          n_done++;
          if (done_at < 0) done_at = k;
          chk("ignore result", {26'd0, s4, c4, v4}, {26'd0, 4'b0101, 1'b1, 1'b0});
        end
      end
      chk("ignore done_count", 32'(n_done), 32'd1);
      chk("ignore done_cycle", 32'(done_at), 32'd5);
    end

    // Reset in the middle of RUN: abort, outputs cleared, no done pulse.
    begin
      int n_done;
      n_done = 0;
      @(negedge clk);
      drive(vecs[6]);
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_run outputs", {25'd0, busy4, done4, s4, c4, v4}, 32'd0);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (done4 !== 1'b0 || busy4 !== 1'b0) n_done++;
      end
      chk("rst_run quiet", 32'(n_done), 32'd0);
      do_op(vecs[1], "after_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled on rising edge of clk.
REQ-005 m  input  1  mode: 0 = add (A+B), 1 = subtract (A-B); sampled with start.
REQ-006 A  input  WIDTH  minuend/addend; sampled with start.
REQ-007 B  input  WIDTH  subtrahend/addend; sampled with start.
REQ-008 busy  output  1  high while a bit-serial operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking the result as updated.
REQ-010 S  output  WIDTH  result, two's-complement modulo 2^WIDTH.
REQ-011 c  output  1  carry out of MSB; in subtract mode, 1 = no borrow (A >= B unsigned).
REQ-012 v  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-013 The block SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 SHALL latch A, (B XOR {WIDTH{m}}), carry=m, bit index=0, and move to RUN; start=0 stays IDLE.
REQ-015 RUN: each cycle SHALL compute one result bit, LSB first, from latched operand bits and the running carry; WIDTH cycles total.
REQ-016 RUN SHALL record the carry into the MSB position for use in v.
REQ-017 After the cycle processing bit WIDTH-1, the FSM SHALL move to DONE.
REQ-018 Entering DONE SHALL load S, c, v from internal results in the same edge.
REQ-019 done SHALL be 1 for exactly the one cycle the FSM is in DONE.
REQ-020 busy SHALL be 1 exactly while the FSM is in RUN.
REQ-021 Latency: start sampled at edge t gives busy high for cycles t+1..t+WIDTH and done high in cycle t+WIDTH+1.
REQ-022 DONE with start=1 SHALL accept the new operation as in IDLE (back-to-back, no idle gap); otherwise go to IDLE.
REQ-023 start during RUN SHALL be ignored; no queuing.
REQ-024 Changes on A, B, m after acceptance SHALL NOT affect the operation in progress.
REQ-025 S, c, v SHALL hold their last values during RUN and IDLE; they change only on entry to DONE or on reset.
REQ-026 Results SHALL be bit-exact with combinational A+B (m=0) or A+~B+1 (m=1) at WIDTH bits.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, S=0, c=0, v=0, and clear the internal shift/carry/index state.
REQ-028 rst takes priority over start; reset during RUN SHALL abort with no done pulse and no output change other than the reset values.
REQ-029 The first start accepted after rst deasserts SHALL behave as from IDLE.

Verification
REQ-030 WIDTH=4, m=1, A=0111, B=0010, start -> done at t+5, S=0101, c=1, v=0; busy high 4 cycles.
REQ-031 WIDTH=4, m=1 back-to-back: 1010-0001 -> S=1001,c=1,v=0; 1111-1101 -> S=0010,c=1,v=0; 0011-1110 -> S=0101,c=0,v=0; start held in DONE, no idle cycles.
REQ-032 WIDTH=4, m=0, A=0111, B=0001 -> S=1000, c=0, v=1; A=1000, B=1000 -> S=0000, c=1, v=1.
REQ-033 WIDTH=8, m=1, A=0x80, B=0x01 -> S=0x7F, c=1, v=1; m=0, A=0xFF, B=0x01 -> S=0x00, c=1, v=0.
REQ-034 WIDTH=4: start, then start pulse plus changed A/B/m at cycle t+2 -> ignored, result of first operation only, single done.
REQ-035 WIDTH=4: rst asserted at cycle t+2 of RUN -> busy=0, done never pulses, S/c/v=0; next start completes normally.
